// File: rtl/polygraph_sequencer.sv
// Front-end sequencer for the polygraph detector: gathers age plus BP/BR/HB triples
// from a shared valid/ready bus, emits frames, and tracks detector alarm runs.
module polygraph_sequencer #(
   parameter int DW        = 10,
   parameter int DET_LAT   = 1,
   parameter int ALARM_RUN = 3,
   parameter int TIMEOUT   = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] age,
   output logic [DW-1:0] bloodP,
   output logic [DW-1:0] breathR,
   output logic [DW-1:0] heartB,
   output logic          frame_valid,
   input  logic          alarm,
   output logic          lie_flag,
   output logic [15:0]   frame_count,
   output logic          timeout_err,
   output logic          busy
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(ALARM_RUN + 1);
   localparam int LW = 4;

   typedef enum logic [2:0] {
      IDLE,
      AGE,
      CAP_BP,
      CAP_BR,
      CAP_HB,
      EMIT,
      WAIT_DET
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] age_q, age_d;
   logic [DW-1:0] bloodp_q, bloodp_d;
   logic [DW-1:0] breathr_q, breathr_d;
   logic [DW-1:0] heartb_q, heartb_d;
   logic [DW-1:0] bp_sh_q, bp_sh_d;
   logic [DW-1:0] br_sh_q, br_sh_d;
   logic          frame_valid_q, frame_valid_d;
   logic          lie_flag_q, lie_flag_d;
   logic [15:0]   frame_count_q, frame_count_d;
   logic          timeout_err_q, timeout_err_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] run_q, run_d;
   logic [LW-1:0] det_cnt_q, det_cnt_d;

   logic xfer;
   logic in_capture;
   logic timeout_hit;

   assign in_ready = (state_q == AGE || state_q == CAP_BP ||
                      state_q == CAP_BR || state_q == CAP_HB) && !start;
   assign xfer        = in_valid && in_ready;
   assign in_capture  = (state_q == CAP_BR) || (state_q == CAP_HB);
   assign timeout_hit = in_capture && !xfer && (timer_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d       = state_q;
      age_d         = age_q;
      bloodp_d      = bloodp_q;
      breathr_d     = breathr_q;
      heartb_d      = heartb_q;
      bp_sh_d       = bp_sh_q;
      br_sh_d       = br_sh_q;
      frame_valid_d = 1'b0;
      lie_flag_d    = lie_flag_q;
      frame_count_d = frame_count_q;
      timeout_err_d = 1'b0;
      run_d         = run_q;
      det_cnt_d     = det_cnt_q;

      if (start) begin
         state_d       = AGE;
         frame_count_d = '0;
         run_d         = '0;
         lie_flag_d    = 1'b0;
         bp_sh_d       = '0;
         br_sh_d       = '0;
      end else begin
         case (state_q)
            IDLE: ;
            AGE: begin
               if (xfer) begin
                  age_d   = in_data;
                  state_d = CAP_BP;
               end
            end
            CAP_BP: begin
               if (xfer) begin
                  bp_sh_d = in_data;
                  state_d = CAP_BR;
               end
            end
            CAP_BR: begin
               if (xfer) begin
                  br_sh_d = in_data;
                  state_d = CAP_HB;
               end else if (timeout_hit) begin
                  state_d       = CAP_BP;
                  bp_sh_d       = '0;
                  br_sh_d       = '0;
                  timeout_err_d = 1'b1;
               end
            end
            CAP_HB: begin
               // Frame outputs load here so they change only on the edge entering EMIT.
               if (xfer) begin
                  bloodp_d      = bp_sh_q;
                  breathr_d     = br_sh_q;
                  heartb_d      = in_data;
                  frame_valid_d = 1'b1;
                  state_d       = EMIT;
                  if (frame_count_q != 16'hFFFF) frame_count_d = frame_count_q + 16'd1;
               end else if (timeout_hit) begin
                  state_d       = CAP_BP;
                  bp_sh_d       = '0;
                  br_sh_d       = '0;
                  timeout_err_d = 1'b1;
               end
            end
            EMIT: begin
               state_d   = WAIT_DET;
               det_cnt_d = LW'(DET_LAT - 1);
            end
            WAIT_DET: begin
               if (det_cnt_q == '0) begin
                  state_d = CAP_BP;
                  if (alarm) begin
                     if (run_q != RW'(ALARM_RUN)) run_d = run_q + 1'b1;
                     if (run_q >= RW'(ALARM_RUN - 1)) lie_flag_d = 1'b1;
                  end else begin
                     run_d = '0;
                  end
               end else begin
                  det_cnt_d = det_cnt_q - 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Watchdog runs only while parked in a capture state with no progress.
   always_comb begin
      timer_d = '0;
      if (!start && in_capture && !xfer && state_d == state_q)
         timer_d = timer_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         age_q         <= '0;
         bloodp_q      <= '0;
         breathr_q     <= '0;
         heartb_q      <= '0;
         bp_sh_q       <= '0;
         br_sh_q       <= '0;
         frame_valid_q <= 1'b0;
         lie_flag_q    <= 1'b0;
         frame_count_q <= '0;
         timeout_err_q <= 1'b0;
         timer_q       <= '0;
         run_q         <= '0;
         det_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         age_q         <= age_d;
         bloodp_q      <= bloodp_d;
         breathr_q     <= breathr_d;
         heartb_q      <= heartb_d;
         bp_sh_q       <= bp_sh_d;
         br_sh_q       <= br_sh_d;
         frame_valid_q <= frame_valid_d;
         lie_flag_q    <= lie_flag_d;
         frame_count_q <= frame_count_d;
         timeout_err_q <= timeout_err_d;
         timer_q       <= timer_d;
         run_q         <= run_d;
         det_cnt_q     <= det_cnt_d;
      end
   end

   assign age         = age_q;
   assign bloodP      = bloodp_q;
   assign breathR     = breathr_q;
   assign heartB      = heartb_q;
   assign frame_valid = frame_valid_q;
   assign lie_flag    = lie_flag_q;
   assign frame_count = frame_count_q;
   assign timeout_err = timeout_err_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: doc/polygraph_sequencer.md
Name: polygraph_sequencer

Overview:
- Front-end controller for the polygraph detector. Accepts sensor words one at a time on a single shared bus with a valid/ready handshake.
- Word order per session: one age word first, then repeating triples of blood pressure, breath rate and heart beat.
- Each complete triple is presented to the detector as one frame with a one-cycle strobe. The block then samples the detector alarm at a fixed latency.
- Tracks consecutive alarm frames to raise a sticky lie flag. A watchdog discards stalled partial frames.

Parameters:
- DW, 10: width of every sensor/age word.
- DET_LAT, 1: cycles from the frame_valid cycle to the cycle in which alarm is sampled (1..15).
- ALARM_RUN, 3: consecutive alarmed frames needed to set lie_flag (1..15).
- TIMEOUT, 64: idle cycles allowed inside a partial frame before it is discarded.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: begin or restart a session.
- in_data, input, DW: sensor word.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: sequencer accepts a word this cycle.
- age, output, DW: session age word.
- bloodP, output, DW: frame blood pressure.
- breathR, output, DW: frame breath rate.
- heartB, output, DW: frame heart beat.
- frame_valid, output, 1: one-cycle pulse; new frame on bloodP/breathR/heartB.
- alarm, input, 1: detector alarm.
- lie_flag, output, 1: sticky; ALARM_RUN consecutive alarmed frames seen.
- frame_count, output, 16: frames emitted this session; saturates at 16'hFFFF.
- timeout_err, output, 1: one-cycle pulse when a partial frame is discarded.
- busy, output, 1: state != IDLE.

Behaviour:
- Reset (synchronous, reset high at a rising edge):
  - state returns to IDLE.
  - All outputs, shadow registers, timer, run counter and frame_count go to 0. in_ready is 0.
  - Reset overrides start and every other input. Reset mid-frame discards all partial data.
- States: IDLE, AGE, CAP_BP, CAP_BR, CAP_HB, EMIT, WAIT_DET.
- Transfer: a word transfers when in_valid && in_ready at a rising edge.
- in_ready = (state is AGE, CAP_BP, CAP_BR or CAP_HB) && !start. It is combinational from registered state and start.
- start: when high in any state (reset low), the next state is AGE. The same edge clears frame_count, the run counter, lie_flag and the shadow registers. start wins over a simultaneous word; that word is not consumed.
- IDLE: waits for start.
- AGE: a transfer loads the age output directly, then goes to CAP_BP.
- CAP_BP / CAP_BR / CAP_HB:
  - A transfer stores in_data into the matching shadow register and advances BP -> BR -> HB.
  - A transfer in CAP_HB goes to EMIT.
- EMIT:
  - On the edge entering EMIT, bloodP/breathR/heartB load from the shadows (heartB from the in_data just transferred).
  - These outputs change only on this edge and hold until the next EMIT.
  - In EMIT, frame_valid=1; frame_count increments (saturating).
  - Latency: frame_valid is high exactly one cycle after the heartB transfer.
  - Next state is WAIT_DET.
- WAIT_DET:
  - A down-counter loaded with DET_LAT-1 on entry; the state lasts DET_LAT cycles.
  - alarm is sampled at the edge ending the last WAIT_DET cycle, i.e. in the cycle DET_LAT after the frame_valid cycle. Then go to CAP_BP.
  - alarm=1: the run counter increments, saturating at ALARM_RUN. When it reaches ALARM_RUN, lie_flag sets.
  - alarm=0: the run counter clears; lie_flag is unchanged (sticky).
  - alarm is ignored in every other state.
- Watchdog:
  - The timer counts cycles spent in CAP_BR or CAP_HB without a transfer, and clears on any transfer or state change.
  - When the timer reaches TIMEOUT-1 with no transfer that cycle, the next state is CAP_BP, the shadows clear, and timeout_err pulses high for one cycle.
  - A transfer on that same cycle wins; no timeout occurs.
  - No timeout in AGE or CAP_BP (an idle gap between frames is legal).
- Outputs are not changed by a timeout. frame_count does not increment on a timeout.
- All registers update only on the rising edge of clk. No combinational path from in_data to any output.

Test Plan:
1. Reset, start, then feed age=25, BP=120, BR=16, HB=72 with in_valid held high:
   - in_ready is high 4 consecutive cycles.
   - frame_valid pulses 1 cycle after the HB transfer, with bloodP=120, breathR=16, heartB=72, age=25.
   - frame_count=1 after the frame_valid cycle.
   - in_ready is low during EMIT and WAIT_DET.
2. DET_LAT=1, three frames with alarm driven 1 only in the sample cycle:
   - lie_flag rises after the third sample.
   - A fourth frame with alarm=0 keeps lie_flag=1.
   - Sequence alarm 1,1,0,1,1 gives no lie_flag.
3. Feed BP=130, BR=18, then stall in_valid low for 64 cycles:
   - timeout_err pulses once; state returns to CAP_BP; bloodP/breathR/heartB unchanged; frame_count unchanged.
   - The next triple 110/15/70 emits correctly.
4. Stall 63 cycles in CAP_HB, then transfer on cycle 64:
   - No timeout_err; the frame emits.
5. Assert start together with in_valid in CAP_BR (in_data=99):
   - Word not consumed; state goes to AGE; frame_count=0; lie_flag=0.
   - The next word is taken as age.
6. Assert reset in WAIT_DET, then in CAP_HB:
   - All outputs read 0 the next cycle; busy=0; no frame_valid follows until a new start.
